// File: rtl/jtframe_snd_gain.sv
// Output gain stage: serial shift-add multiply of the filtered sample by an unsigned
// fixed-point gain, then 16-bit saturation. Optional peak meter under JTFRAME_SND_PEAK_EN.
module jtframe_snd_gain #(
  parameter int unsigned GW    = 8,
  parameter int unsigned GFRAC = 4
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              sample,
  input  logic [15:0]       din,
  input  logic [GW-1:0]     gain,
  output logic [15:0]       dout,
  output logic              dout_stb,
  output logic              busy,
  output logic              sat,
  output logic              missed,
  output logic [15:0]       peak
);

  localparam int unsigned AW = 16 + GW;
  localparam int unsigned CW = (GW > 1) ? $clog2(GW) : 1;
  localparam logic signed [AW-1:0] MAXV = {{GW{1'b0}}, 16'h7fff};
  localparam logic signed [AW-1:0] MINV = {{GW{1'b1}}, 16'h8000};

  typedef enum logic [1:0] {IDLE, MUL, SAT} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [AW-1:0]   mcand_q, mcand_d;
  logic [GW-1:0]   g_q, g_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     dout_q, dout_d;
  logic            stb_q, stb_d;
  logic            busy_q, busy_d;
  logic            sat_q, sat_d;
  logic            missed_q, missed_d;
  logic [15:0]     peak_q, peak_d;
  logic signed [AW-1:0] r_c;

  // busy_q stays high through the strobe cycle, so it alone gates new samples
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    g_d      = g_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    stb_d    = 1'b0;
    sat_d    = 1'b0;
    busy_d   = busy_q;
    missed_d = sample & busy_q;
    r_c      = $signed(acc_q) >>> GFRAC;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (sample && !busy_q) begin
          acc_d   = '0;
          mcand_d = {{GW{din[15]}}, din};
          g_d     = gain;
          cnt_d   = CW'(GW - 1);
          busy_d  = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        if (g_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        g_d     = g_q >> 1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = SAT;
      end
      SAT: begin
        stb_d   = 1'b1;
        state_d = IDLE;
        if (r_c > MAXV) begin
          dout_d = 16'h7fff;
          sat_d  = 1'b1;
        end else if (r_c < MINV) begin
          dout_d = 16'h8000;
          sat_d  = 1'b1;
        end else begin
          dout_d = r_c[15:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef JTFRAME_SND_PEAK_EN
  logic [15:0] abs_c;

  // Peak follows attacks instantly and decays by 1/256 per result
  always_comb begin
    peak_d = peak_q;
    abs_c  = dout_d;
    if (dout_d[15]) abs_c = (dout_d == 16'h8000) ? 16'h7fff : 16'(-dout_d);
    if (state_q == SAT) begin
      if (abs_c > peak_q) peak_d = abs_c;
      else                peak_d = peak_q - (peak_q >> 8);
    end
  end
`else
  always_comb peak_d = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      g_q      <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      stb_q    <= 1'b0;
      busy_q   <= 1'b0;
      sat_q    <= 1'b0;
      missed_q <= 1'b0;
      peak_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      g_q      <= g_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      stb_q    <= stb_d;
      busy_q   <= busy_d;
      sat_q    <= sat_d;
      missed_q <= missed_d;
      peak_q   <= peak_d;
    end
  end

  assign dout     = dout_q;
  assign dout_stb = stb_q;
  assign busy     = busy_q;
  assign sat      = sat_q;
  assign missed   = missed_q;
  assign peak     = peak_q;

endmodule
